accuml_ctrl: RTL and testbench
==============================

Name: accuml_ctrl

Overview:
Frame sequencer for one attached accuml accumulator instance. It clears the accumulator, feeds it exactly `len` signed-operation samples over a valid/ready stream, then captures the (WIDTH+1)-bit sum into a held result register with a valid/ready output handshake. It sits between a sample producer and a result consumer and owns the accumulator's `clr`, `add_sub` and `D` inputs.

Parameters:
WIDTH, 16, sample width; accumulator output width is WIDTH+1.
LEN_W, 8, width of the frame-length input; maximum frame length is 2^LEN_W-1.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  frame start request; sampled only in IDLE.
len  input  LEN_W  samples per frame; sampled when start is accepted.
abort  input  1  abandon the current frame.
busy  output  1  high in every state except IDLE.
s_valid  input  1  sample valid.
s_ready  output  1  sample ready; high only in RUN.
s_data  input  WIDTH  sample value.
s_sub  input  1  1 = subtract sample, 0 = add.
m_valid  output  1  result valid.
m_ready  input  1  result accepted.
m_data  output  WIDTH+1  held frame sum.
acc_clr  output  1  to accumulator clr.
acc_add_sub  output  1  to accumulator add_sub.
acc_D  output  WIDTH  to accumulator D.
acc_Q  input  WIDTH+1  from accumulator Q.

Behaviour:
- Accumulator contract: Q is registered. clr=1 gives Q<=0 at the next edge. Otherwise Q<=Q+D (add_sub=0) or Q-D (add_sub=1), mod 2^(WIDTH+1).
- Reset (reset=0, asynchronous): state=IDLE, count=0, m_data=0, and all outputs 0.
- acc_D=0 and acc_add_sub=0 in every cycle without an accepted sample, so the accumulator holds.
- FSM IDLE:
  - On start=1 and abort=0, latch len into len_r and go to CLEAR.
  - start while busy is ignored.
- FSM CLEAR (1 cycle):
  - acc_clr=1, count<=0.
  - If len_r==0, go to DRAIN; otherwise go to RUN.
- FSM RUN:
  - s_ready=1.
  - On a handshake (s_valid&s_ready): acc_D=s_data and acc_add_sub=s_sub combinationally in the same cycle; count<=count+1.
  - When the handshake is the len_r-th sample, go to DRAIN.
  - Idle cycles with s_valid=0 are allowed with no limit.
- FSM DRAIN (1 cycle):
  - acc_Q now includes the last sample.
  - m_data<=acc_Q, then go to DONE.
- FSM DONE:
  - m_valid=1; m_data is held stable.
  - On m_ready=1, go to IDLE with m_valid=0 next cycle.
  - m_ready while m_valid=0 is ignored.
- Latency:
  - start accepted at edge 0; acc_clr high in cycle 1; s_ready first high in cycle 2.
  - Last handshake at edge k; m_valid high from the cycle after edge k+1, i.e. 2 cycles after the last handshake.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; count cleared; no result produced; m_valid drops next cycle; m_data keeps its old value.
  - A sample handshake in the same cycle is still driven to the accumulator; the accumulator is cleared on the next frame's CLEAR.
  - abort has priority over start in IDLE.
- Arithmetic: overflow and underflow wrap modulo 2^(WIDTH+1), as in the accumulator. No saturation and no flag.
- busy=1 in CLEAR, RUN, DRAIN and DONE.

Test Plan:
- Add frame: reset, then start with len=4; four samples of 16'd10000, s_sub=0, back-to-back -> acc_clr pulses once; m_data=17'd40000; m_valid asserts 2 cycles after the 4th handshake.
- Mixed frame: len=3; samples +100, -50 (s_sub=1), +7, with s_valid gaps of 2 cycles -> m_data=57; acc_D=0 during gaps; s_ready high throughout RUN.
- Backpressure and wrap: len=2; samples 0 then 1 with s_sub=1 -> m_data=17'h1FFFF; m_ready held low 5 cycles -> m_valid and m_data stable; busy=1 until the cycle after m_ready.
- len=0: start -> CLEAR then DRAIN; m_data=0, m_valid=1 three cycles after start; s_ready never asserted.
- Abort and ignored start: abort after 2 of 5 samples -> IDLE, no m_valid; start pulsed while busy in a later frame -> ignored; the next normal len=1 frame with sample 9 -> m_data=9, with no residue from the aborted frame.
- Reset mid-frame: drive reset low asynchronously in RUN -> all outputs 0 immediately; after release, IDLE with s_ready=0 until a new start.

Source files
------------

// File: rtl/accuml_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accuml_ctrl
// Description : Frame sequencer for one accuml accumulator. Clears the
//               accumulator, streams exactly len samples into it, then holds
//               the (WIDTH+1)-bit sum behind a valid/ready result port.
// Revision    : 1.0  initial release
// ============================================================================
module accuml_ctrl #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sub,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH:0]   m_data,
    output logic             acc_clr,
    output logic             acc_add_sub,
    output logic [WIDTH-1:0] acc_D,
    input  logic [WIDTH:0]   acc_Q
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_inc;
    logic [WIDTH:0]   r_m_data;
    logic             w_hs;
    logic             w_last;
    logic             w_accept;
    logic             w_abort;

    // s_ready is high for the whole of RUN, so a valid sample in RUN is a handshake
    assign w_hs        = (r_state == c_RUN) && s_valid;
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_last      = w_hs && (w_count_inc == r_len);
    assign w_accept    = (r_state == c_IDLE) && start && !abort;
    assign w_abort     = abort && (r_state != c_IDLE);
    assign m_data      = r_m_data;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_CLEAR;
            c_CLEAR: w_state_next = (r_len == '0) ? c_DRAIN : c_RUN;
            c_RUN:   if (w_last) w_state_next = c_DRAIN;
            c_DRAIN: w_state_next = c_DONE;
            c_DONE:  if (m_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = c_IDLE;
        end
    end

    // Outputs: state decodes plus the accepted sample steered to the accumulator
    always_comb begin
        busy        = (r_state != c_IDLE);
        s_ready     = (r_state == c_RUN);
        acc_clr     = (r_state == c_CLEAR);
        m_valid     = (r_state == c_DONE);
        acc_D       = '0;
        acc_add_sub = 1'b0;
        if (w_hs) begin
            acc_D       = s_data;
            acc_add_sub = s_sub;
        end
    end

    // Frame length latch, sample counter and held result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len    <= '0;
            r_count  <= '0;
            r_m_data <= '0;
        end else begin
            if (w_accept) begin
                r_len <= len;
            end
            if (w_abort || (r_state == c_CLEAR)) begin
                r_count <= '0;
            end else if (w_hs) begin
                r_count <= w_count_inc;
            end
            // Q already includes the final sample during DRAIN
            if ((r_state == c_DRAIN) && !abort) begin
                r_m_data <= acc_Q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accuml_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_accuml_ctrl
// Description : Self-checking bench for accuml_ctrl with an attached
//               accumulator and a frame-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_accuml_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_sub;
    logic        m_valid;
    logic        m_ready;
    logic [16:0] m_data;
    logic        acc_clr;
    logic        acc_add_sub;
    logic [15:0] acc_D;
    logic [16:0] acc_Q = '0;

    int n_pass      = 0;
    int n_total     = 0;
    int clr_seen    = 0;
    int sready_seen = 0;

    // Frame-level reference model: cycle index within the frame, samples
    // wanted/taken, cycle in which the result is captured, running sum.
    bit          mf_in;
    int          mf_cyc;
    int          mf_need;
    int          mf_got;
    int          mf_drain;
    logic [16:0] mf_sum;
    logic [16:0] mf_res;

    accuml_ctrl #(.WIDTH(16), .LEN_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .busy        (busy),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sub       (s_sub),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .acc_clr     (acc_clr),
        .acc_add_sub (acc_add_sub),
        .acc_D       (acc_D),
        .acc_Q       (acc_Q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Attached accumulator
    always @(posedge clock) begin
        if (acc_clr)          acc_Q <= '0;
        else if (acc_add_sub) acc_Q <= acc_Q - {1'b0, acc_D};
        else                  acc_Q <= acc_Q + {1'b0, acc_D};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit exp_sready();
        return mf_in && (mf_cyc >= 2) && (mf_got < mf_need);
    endfunction

    function automatic bit exp_mvalid();
        return mf_in && (mf_drain >= 0) && (mf_cyc > mf_drain);
    endfunction

    task automatic model_reset();
        mf_in    = 1'b0;
        mf_cyc   = 0;
        mf_need  = 0;
        mf_got   = 0;
        mf_drain = -1;
        mf_sum   = '0;
        mf_res   = '0;
    endtask

    task automatic compare();
        bit hs;
        hs = exp_sready() && s_valid;
        if (acc_clr === 1'b1) clr_seen++;
        if (s_ready === 1'b1) sready_seen++;
        check("busy",        32'(busy),        32'(mf_in));
        check("acc_clr",     32'(acc_clr),     32'(mf_in && mf_cyc == 1));
        check("s_ready",     32'(s_ready),     32'(exp_sready()));
        check("acc_D",       32'(acc_D),       hs ? 32'(s_data) : 32'd0);
        check("acc_add_sub", 32'(acc_add_sub), 32'(hs && s_sub));
        check("m_valid",     32'(m_valid),     32'(exp_mvalid()));
        check("m_data",      32'(m_data),      32'(mf_res));
    endtask

    task automatic model_update();
        bit hs;
        bit mv;
        if (!reset) begin
            model_reset();
            return;
        end
        hs = exp_sready() && s_valid;
        mv = exp_mvalid();
        if (!mf_in) begin
            if (start && !abort) begin
                mf_in    = 1'b1;
                mf_cyc   = 1;
                mf_need  = int'(len);
                mf_got   = 0;
                mf_sum   = '0;
                mf_drain = (len == 8'd0) ? 2 : -1;
            end
        end else if (abort) begin
            mf_in = 1'b0;
        end else begin
            if (hs) begin
                mf_sum = s_sub ? mf_sum - {1'b0, s_data} : mf_sum + {1'b0, s_data};
                mf_got++;
                if (mf_got == mf_need) mf_drain = mf_cyc + 1;
            end
            if (mf_cyc == mf_drain) mf_res = mf_sum;
            if (mv && m_ready) mf_in = 1'b0;
            mf_cyc++;
        end
    endtask

    // One clock cycle: compare on the falling edge, advance model on the rising edge
    task automatic cyc();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_data  = '0;
        s_sub   = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [15:0] d, input logic sub);
        s_valid = 1'b1;
        s_data  = d;
        s_sub   = sub;
        cyc();
    endtask

    task automatic begin_frame(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        cyc();
        start = 1'b0;
    endtask

    task automatic accept_result();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        len     = '0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sub   = 1'b0;
        m_ready = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_mdata",  32'(m_data),  32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        idle(2);

        // Add frame: 4 x 10000, back-to-back
        clr_seen = 0;
        begin_frame(8'd4);
        cyc();
        for (int i = 0; i < 4; i++) send(16'd10000, 1'b0);
        s_valid = 1'b0;
        check("add_drain_mvalid", 32'(m_valid), 32'd0);
        cyc();
        check("add_mvalid", 32'(m_valid), 32'd1);
        check("add_mdata",  32'(m_data),  32'd40000);
        check("add_clr_pulses", 32'(clr_seen), 32'd1);
        accept_result();
        check("add_idle_busy", 32'(busy), 32'd0);
        idle(2);

        // Mixed frame with 2-cycle gaps: 100 - 50 + 7
        begin_frame(8'd3);
        cyc();
        send(16'd100, 1'b0);
        idle(2);
        send(16'd50, 1'b1);
        idle(2);
        send(16'd7, 1'b0);
        idle(1);
        check("mix_mvalid", 32'(m_valid), 32'd1);
        check("mix_mdata",  32'(m_data),  32'd57);
        accept_result();
        idle(1);

        // Backpressure and wrap: 0 then -1
        begin_frame(8'd2);
        cyc();
        send(16'd0, 1'b0);
        send(16'd1, 1'b1);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            check("bp_mvalid", 32'(m_valid), 32'd1);
            check("bp_mdata",  32'(m_data),  32'h1FFFF);
            cyc();
        end
        check("bp_busy", 32'(busy), 32'd1);
        accept_result();
        check("bp_busy_after", 32'(busy), 32'd0);
        idle(1);

        // Zero-length frame
        sready_seen = 0;
        begin_frame(8'd0);
        cyc();
        cyc();
        check("len0_mvalid", 32'(m_valid), 32'd1);
        check("len0_mdata",  32'(m_data),  32'd0);
        check("len0_sready", 32'(sready_seen), 32'd0);
        accept_result();
        idle(1);

        // Abort after 2 of 5 samples
        begin_frame(8'd5);
        cyc();
        send(16'd11, 1'b0);
        send(16'd22, 1'b0);
        s_valid = 1'b0;
        abort   = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy",   32'(busy),    32'd0);
        check("abort_mvalid", 32'(m_valid), 32'd0);
        check("abort_mdata",  32'(m_data),  32'd0);
        idle(3);

        // len=1 frame with start held high while busy
        start = 1'b1;
        len   = 8'd1;
        cyc();
        len = 8'd3;
        cyc();
        send(16'd9, 1'b0);
        start   = 1'b0;
        s_valid = 1'b0;
        cyc();
        check("one_mvalid", 32'(m_valid), 32'd1);
        check("one_mdata",  32'(m_data),  32'd9);
        accept_result();
        idle(1);

        // Asynchronous reset in the middle of RUN
        begin_frame(8'd3);
        cyc();
        send(16'd5, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        check("arst_sready", 32'(s_ready), 32'd0);
        check("arst_busy",   32'(busy),    32'd0);
        check("arst_accD",   32'(acc_D),   32'd0);
        check("arst_mdata",  32'(m_data),  32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("post_rst_sready", 32'(s_ready), 32'd0);
        check("post_rst_busy",   32'(busy),    32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
